// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - two-requester round-robin arbiter driving a single APB master port
module apb_arb_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              req_gnt,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   // counter must be able to hold TIMEOUT; keep one bit when timeout is disabled
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                 state;
   logic                   prio;      // requester that wins when both are valid
   logic                   owner;     // requester of the transfer currently on the bus
   logic [CW-1:0]          wait_cnt;
   logic                   arb_en;
   logic                   win;
   logic                   timeout_hit;
   logic                   ld_write;
   logic [ADDR_WIDTH-1:0]  ld_addr;
   logic [DATA_WIDTH-1:0]  ld_wdata;

   // arbitration window, round-robin winner selection, winner payload mux and timeout detect
   always_comb begin
      arb_en      = !PRESET && ((state == IDLE) || ((state == ACCESS) && PREADY));
      timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !PREADY &&
                    (wait_cnt == CW'(TIMEOUT - 1));
      win         = (req_valid == 2'b11) ? prio : req_valid[1];
      req_gnt     = 2'b00;
      if (arb_en && (req_valid != 2'b00)) begin
         req_gnt[win] = 1'b1;
      end
      ld_write = req_write[win];
      ld_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      ld_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
   end

   // transfer FSM; a grant (IDLE or completing ACCESS) overrides the state's own next step
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
         prio      <= 1'b0;
         owner     <= 1'b0;
      end else begin
         rsp_valid <= 2'b00;
         case (state)
            SETUP: begin
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  rsp_valid[owner] <= 1'b1;
                  rsp_rdata        <= PWRITE ? '0 : PRDATA;
                  rsp_err          <= PSLVERR;
                  PSEL             <= 1'b0;
                  PENABLE          <= 1'b0;
                  state            <= IDLE;
               end else if (timeout_hit) begin
                  rsp_valid[owner] <= 1'b1;
                  rsp_rdata        <= '0;
                  rsp_err          <= 1'b1;
                  PSEL             <= 1'b0;
                  PENABLE          <= 1'b0;
                  wait_cnt         <= wait_cnt + 1'b1;
                  state            <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (req_gnt != 2'b00) begin
            PADDR   <= ld_addr;
            PWRITE  <= ld_write;
            PWDATA  <= ld_wdata;
            owner   <= win;
            prio    <= ~win;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
         end
      end
   end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, APB address width; DATA_WIDTH, default 32, APB data width; TIMEOUT, default 16, ACCESS wait-cycle limit (0 disables timeout).
REQ-002 Ports SHALL be, clock and reset first: PCLK in 1 APB clock; PRESET in 1 reset.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Requester ports SHALL be: req_valid in 2 per-requester request; req_write in 2 per-requester direction (1=write); req_addr in 2*ADDR_WIDTH packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]; req_wdata in 2*DATA_WIDTH packed write data, same packing.
REQ-005 Response ports SHALL be: req_gnt out 2 one-hot request-accepted pulse; rsp_valid out 2 one-hot completion pulse; rsp_rdata out DATA_WIDTH read data; rsp_err out 1 error flag.
REQ-006 APB ports SHALL be: PSEL out 1; PENABLE out 1; PADDR out ADDR_WIDTH; PWRITE out 1; PWDATA out DATA_WIDTH; PRDATA in DATA_WIDTH; PREADY in 1; PSLVERR in 1.

Function
REQ-007 FSM SHALL have states IDLE, SETUP and ACCESS; all APB outputs, rsp_valid, rsp_rdata and rsp_err SHALL be registered; req_gnt SHALL be combinational from state and req_valid.
REQ-008 Arbitration SHALL occur in IDLE, and in an ACCESS cycle with PREADY=1 (back-to-back); if any req_valid=1, exactly one req_gnt bit SHALL be 1 in that cycle, and the winner's write/addr/wdata SHALL be latched.
REQ-009 Round-robin: a single requester SHALL win whenever it alone is valid; with both valid, the requester not granted last SHALL win; after reset requester 0 SHALL have priority.
REQ-010 Requesters SHALL hold req_valid and payload until req_gnt; the block SHALL NOT sample a payload outside its grant cycle.
REQ-011 Grant in cycle C -> SETUP in C+1 (PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values) -> ACCESS from C+2 (PSEL=1, PENABLE=1).
REQ-012 PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the final ACCESS cycle; PSEL SHALL stay 1 throughout.
REQ-013 ACCESS SHALL repeat while PREADY=0; PRDATA and PSLVERR SHALL be sampled only in an ACCESS cycle with PREADY=1.
REQ-014 Completion cycle A (ACCESS, PREADY=1): in A+1, rsp_valid[owner]=1 for one cycle; rsp_rdata=PRDATA for reads, 0 for writes; rsp_err=PSLVERR.
REQ-015 After completion, next state SHALL be SETUP if a grant occurred in A, else IDLE with PSEL=0, PENABLE=0.
REQ-016 In IDLE, PADDR/PWRITE/PWDATA SHALL hold their last values.
REQ-017 Wait counter (width $clog2(TIMEOUT+1)) SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-018 If TIMEOUT>0 and the counter reaches TIMEOUT: abort; next cycle rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, PSEL=0, PENABLE=0, state IDLE; no grant in the abort cycle.
REQ-019 rsp_rdata and rsp_err SHALL hold their values when rsp_valid=0.

Reset
REQ-020 While PRESET=1 (asynchronous): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, wait counter all 0; round-robin priority to requester 0; req_gnt=0.
REQ-021 Reset during SETUP or ACCESS SHALL drop PSEL/PENABLE immediately; the interrupted transfer SHALL produce no rsp_valid.
REQ-022 After PRESET deasserts, the first grant SHALL occur no earlier than the first clock edge following deassertion.

Verification
REQ-023 Single read: req_valid=01, addr0=0x10, PREADY=1 in first ACCESS, PRDATA=0xDEADBEEF -> gnt=01 in C, SETUP C+1, ACCESS C+2, rsp_valid=01 in C+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-024 Contention: both valid continuously, PREADY=1 -> grants alternate 01,10,01,... back-to-back with no IDLE cycle between transfers.
REQ-025 Wait states: write, PREADY low for 3 ACCESS cycles then high with PSLVERR=1 -> PADDR/PWDATA stable for all 4 ACCESS cycles; rsp_err=1, rsp_rdata=0.
REQ-026 Timeout: TIMEOUT=4, PREADY stuck 0 -> after 4 ACCESS cycles PSEL drops, rsp_valid pulses with rsp_err=1, rsp_rdata=0.
REQ-027 Reset mid-ACCESS: assert PRESET while PENABLE=1 -> PSEL=PENABLE=0 immediately, no rsp_valid; after release, a pending req_valid=10 is granted.
